demux_1a4_32bit: RTL and testbench

DEMUX_1A4_32BIT -- requirements
Module: demux_1a4_32bit

---
 rtl/demux_1a4_32bit.sv | 71 +++++++
 tb/tb_demux_1a4_32bit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/demux_1a4_32bit.sv
// 1-to-4 demultiplexer with a one-entry registered slot per destination,
// valid/ready handshakes on both sides and a wrapping delivery counter per output.
module demux_1a4_32bit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       SEL,
  input  logic [WIDTH-1:0] IN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] OUT0,
  output logic [WIDTH-1:0] OUT1,
  output logic [WIDTH-1:0] OUT2,
  output logic [WIDTH-1:0] OUT3,
  output logic [3:0]       OUT_VALID,
  input  logic [3:0]       OUT_READY,
  output logic [CNT_W-1:0] CNT0,
  output logic [CNT_W-1:0] CNT1,
  output logic [CNT_W-1:0] CNT2,
  output logic [CNT_W-1:0] CNT3
);

  logic [3:0][WIDTH-1:0] data_q, data_d;
  logic [3:0]            valid_q, valid_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                  accept;
  logic [3:0]            deliver;

  // Only the addressed slot can stall the source; a slot draining this cycle frees up in time.
  assign IN_READY = ~valid_q[SEL] | OUT_READY[SEL];
  assign accept   = IN_VALID & IN_READY;
  assign deliver  = valid_q & OUT_READY;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~deliver;
    cnt_d   = cnt_q;
    for (int k = 0; k < 4; k++) begin
      if (deliver[k]) cnt_d[k] = cnt_q[k] + CNT_W'(1);
    end
    if (accept) begin
      data_d[SEL]  = IN;
      valid_d[SEL] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q  <= '0;
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign OUT0      = data_q[0];
  assign OUT1      = data_q[1];
  assign OUT2      = data_q[2];
  assign OUT3      = data_q[3];
  assign OUT_VALID = valid_q;
  assign CNT0      = cnt_q[0];
  assign CNT1      = cnt_q[1];
  assign CNT2      = cnt_q[2];
  assign CNT3      = cnt_q[3];

endmodule

// File: tb/tb_demux_1a4_32bit.sv
// Directed bench for demux_1a4_32bit: a table of single-cycle vectors with
// hand-computed expectations, plus sequences for streaming, counter wrap and reset.
module tb_demux_1a4_32bit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  SEL;
  logic [31:0] IN;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] OUT0, OUT1, OUT2, OUT3;
  logic [3:0]  OUT_VALID;
  logic [3:0]  OUT_READY;
  logic [7:0]  CNT0, CNT1, CNT2, CNT3;

  int errors = 0;
  int checks = 0;

  demux_1a4_32bit #(.WIDTH(32), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .SEL(SEL), .IN(IN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT0(OUT0), .OUT1(OUT1), .OUT2(OUT2), .OUT3(OUT3), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .CNT0(CNT0), .CNT1(CNT1), .CNT2(CNT2), .CNT3(CNT3)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] din;
    logic        vin;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_vld;
    logic [1:0]  chk;
    logic [31:0] exp_out;
    logic [7:0]  exp_cnt;
  } vec_t;

  function automatic logic [31:0] out_of(input logic [1:0] k);
    case (k)
      2'd0: return OUT0;
      2'd1: return OUT1;
      2'd2: return OUT2;
      default: return OUT3;
    endcase
  endfunction

  function automatic logic [7:0] cnt_of(input logic [1:0] k);
    case (k)
      2'd0: return CNT0;
      2'd1: return CNT1;
      2'd2: return CNT2;
      default: return CNT3;
    endcase
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] s, input logic [31:0] d, input logic v, input logic [3:0] r);
    SEL = s; IN = d; IN_VALID = v; OUT_READY = r;
  endtask

  // Called 1 time unit after a rising edge; leaves time at 1 unit after the next edge.
  task automatic step(input vec_t v, input int idx);
    drive(v.sel, v.din, v.vin, v.ordy);
    #2;
    check("vec_in_ready", idx, 32'(IN_READY), 32'(v.exp_rdy));
    @(posedge CLK); #1;
    check("vec_out_valid", idx, 32'(OUT_VALID), 32'(v.exp_vld));
    check("vec_out_data", idx, out_of(v.chk), v.exp_out);
    check("vec_cnt", idx, 32'(cnt_of(v.chk)), 32'(v.exp_cnt));
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #2;
    RST = 1'b0;
    tick();
  endtask

  vec_t vecs[10];

  initial begin
    // sel, din, vin, ordy, exp_rdy, exp_vld, chk, exp_out, exp_cnt
    vecs[0] = '{2'd2, 32'hDEADBEEF, 1'b1, 4'b0000, 1'b1, 4'b0100, 2'd2, 32'hDEADBEEF, 8'd0};
    vecs[1] = '{2'd1, 32'h11111111, 1'b1, 4'b0000, 1'b1, 4'b0110, 2'd1, 32'h11111111, 8'd0};
    vecs[2] = '{2'd1, 32'h22222222, 1'b1, 4'b0000, 1'b0, 4'b0110, 2'd1, 32'h11111111, 8'd0};
    vecs[3] = '{2'd3, 32'h33333333, 1'b1, 4'b0000, 1'b1, 4'b1110, 2'd3, 32'h33333333, 8'd0};
    vecs[4] = '{2'd0, 32'h44444444, 1'b0, 4'b0000, 1'b1, 4'b1110, 2'd0, 32'h00000000, 8'd0};
    vecs[5] = '{2'd2, 32'h55555555, 1'b1, 4'b0100, 1'b1, 4'b1110, 2'd2, 32'h55555555, 8'd1};
    vecs[6] = '{2'd1, 32'h66666666, 1'b1, 4'b0010, 1'b1, 4'b1110, 2'd1, 32'h66666666, 8'd1};
    vecs[7] = '{2'd0, 32'h77777777, 1'b1, 4'b0000, 1'b1, 4'b1111, 2'd0, 32'h77777777, 8'd0};
    vecs[8] = '{2'd0, 32'h88888888, 1'b0, 4'b1111, 1'b1, 4'b0000, 2'd3, 32'h33333333, 8'd1};
    vecs[9] = '{2'd0, 32'h99999999, 1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 32'h77777777, 8'd1};

    RST = 1'b1;
    drive(2'd0, 32'h0, 1'b0, 4'b0000);
    tick(); tick();
    check("rst_valid", 0, 32'(OUT_VALID), 32'h0);
    check("rst_out2", 0, OUT2, 32'h0);
    check("rst_in_ready", 0, 32'(IN_READY), 32'h1);
    RST = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) step(vecs[i], i);

    check("all_drain_cnt0", 0, 32'(CNT0), 32'd1);
    check("all_drain_cnt1", 1, 32'(CNT1), 32'd2);
    check("all_drain_cnt2", 2, 32'(CNT2), 32'd2);
    check("all_drain_cnt3", 3, 32'(CNT3), 32'd1);

    // Back-to-back streaming into output 0 while it drains every cycle.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(2'd0, 32'hA0000000 + 32'(i), 1'b1, 4'b0001);
      #2;
      check("stream_in_ready", i, 32'(IN_READY), 32'h1);
      tick();
      check("stream_out0", i, OUT0, 32'hA0000000 + 32'(i));
    end
    drive(2'd0, 32'h0, 1'b0, 4'b0001);
    tick();
    check("stream_cnt0", 0, 32'(CNT0), 32'd10);
    check("stream_valid", 0, 32'(OUT_VALID), 32'h0);

    // Push output 3's counter to 255, then one more delivery wraps it.
    for (int i = 0; i < 256; i++) begin
      drive(2'd3, 32'hC0000000 + 32'(i), 1'b1, 4'b1000);
      tick();
    end
    check("wrap_pre_cnt3", 0, 32'(CNT3), 32'd255);
    check("wrap_pre_valid", 0, 32'(OUT_VALID), 32'b1000);
    drive(2'd3, 32'h0, 1'b0, 4'b1000);
    tick();
    check("wrap_cnt3", 0, 32'(CNT3), 32'd0);
    check("wrap_cnt0", 0, 32'(CNT0), 32'd10);
    check("wrap_cnt1", 0, 32'(CNT1), 32'd0);
    check("wrap_valid", 0, 32'(OUT_VALID), 32'h0);

    // Fill outputs 1 and 3, probe SEL-dependent stall, then reset mid-cycle.
    drive(2'd1, 32'h12345678, 1'b1, 4'b0000);
    tick();
    drive(2'd3, 32'h9ABCDEF0, 1'b1, 4'b0000);
    tick();
    check("fill_valid", 0, 32'(OUT_VALID), 32'b1010);
    drive(2'd1, 32'hBBBBBBBB, 1'b1, 4'b0000);
    #1;
    check("sel_switch_rdy1", 0, 32'(IN_READY), 32'h0);
    SEL = 2'd3;
    #1;
    check("sel_switch_rdy3", 0, 32'(IN_READY), 32'h0);
    SEL = 2'd2;
    #1;
    check("sel_switch_rdy2", 0, 32'(IN_READY), 32'h1);
    SEL = 2'd1;
    RST = 1'b1;
    #1;
    check("async_rst_valid", 0, 32'(OUT_VALID), 32'h0);
    check("async_rst_out1", 0, OUT1, 32'h0);
    check("async_rst_out3", 0, OUT3, 32'h0);
    check("async_rst_cnt0", 0, 32'(CNT0), 32'h0);
    check("async_rst_in_ready", 0, 32'(IN_READY), 32'h1);
    tick();
    check("rst_no_accept", 0, 32'(OUT_VALID), 32'h0);
    RST = 1'b0;
    tick();
    check("post_rst_valid", 0, 32'(OUT_VALID), 32'b0010);
    check("post_rst_out1", 0, OUT1, 32'hBBBBBBBB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
